// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each cycle, picks up to WIDTH completing functional
// units round-robin and registers their destination tags onto the CDB slots.
// fu_grant is combinational; everything on cdb_* is registered (1-cycle latency).
module cdb_arbiter #(
  parameter int NUM_FU        = 4,
  parameter int WIDTH         = 2,
  parameter int PHY_REG_WIDTH = 6,
  localparam int SRC_W        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_FU-1:0]                fu_req,
  input  logic [NUM_FU*PHY_REG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]                fu_grant,
  input  logic                             flush,
  output logic [WIDTH-1:0]                 cdb_valid,
  output logic [WIDTH*PHY_REG_WIDTH-1:0]   cdb_tag,
  output logic [WIDTH*SRC_W-1:0]           cdb_src
);

  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]               cdb_valid_q, cdb_valid_d;
  logic [WIDTH*PHY_REG_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [WIDTH*SRC_W-1:0]         cdb_src_q, cdb_src_d;

  // Round-robin scan from rr_ptr: grant up to WIDTH requesters, pack them into
  // slots in scan order, and move the pointer just past the last winner.
  // Reset and flush both suppress every grant, so requests are held, not consumed.
  always_comb begin
    int unsigned idx;
    int unsigned slot;
    idx         = 0;
    slot        = 0;
    fu_grant    = '0;
    cdb_valid_d = '0;
    cdb_tag_d   = '0;
    cdb_src_d   = '0;
    rr_ptr_d    = rr_ptr_q;
    if (reset && !flush) begin
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        idx = 32'(rr_ptr_q) + j;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (fu_req[idx] && slot < WIDTH) begin
          fu_grant[idx]                              = 1'b1;
          cdb_valid_d[slot]                          = 1'b1;
          cdb_tag_d[slot*PHY_REG_WIDTH +: PHY_REG_WIDTH] = fu_tag[idx*PHY_REG_WIDTH +: PHY_REG_WIDTH];
          cdb_src_d[slot*SRC_W +: SRC_W]             = SRC_W'(idx);
          rr_ptr_d                                   = (idx + 1 == NUM_FU) ? '0 : SRC_W'(idx + 1);
          slot                                       = slot + 1;
        end
      end
    end
  end

  // CDB slot registers and priority pointer; async clear drops any in-flight broadcast.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with default parameters (4 FUs, 2 slots).
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int W  = 2;
  localparam int P  = 6;

  logic          clock;
  logic          reset;
  logic [NF-1:0] fu_req;
  logic [NF*P-1:0] fu_tag;
  logic [NF-1:0] fu_grant;
  logic          flush;
  logic [W-1:0]  cdb_valid;
  logic [W*P-1:0] cdb_tag;
  logic [W*2-1:0] cdb_src;

  logic [P-1:0] tags [NF];

  int n_tests;
  int n_fail;
  int m_ptr;

  cdb_arbiter #(.NUM_FU(NF), .WIDTH(W), .PHY_REG_WIDTH(P)) dut (
    .clock(clock), .reset(reset), .fu_req(fu_req), .fu_tag(fu_tag),
    .fu_grant(fu_grant), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NF; i++) fu_tag[i*P +: P] = tags[i];
  end

  // Reference arbiter: collect requesters in rotated priority order, keep the first W.
  function automatic void model(input logic [NF-1:0] req, input logic fl, input int ptr,
                                output logic [NF-1:0] g, output logic [W-1:0] v,
                                output logic [W*P-1:0] t, output logic [W*2-1:0] s,
                                output int np);
    int q[$];
    g = '0; v = '0; t = '0; s = '0; np = ptr;
    if (!fl) begin
      for (int j = 0; j < NF; j++) begin
        int i;
        i = (ptr + j) % NF;
        if (req[i] && q.size() < W) q.push_back(i);
      end
      foreach (q[k]) begin
        g[q[k]]      = 1'b1;
        v[k]         = 1'b1;
        t[k*P +: P]  = tags[q[k]];
        s[k*2 +: 2]  = 2'(q[k]);
      end
      if (q.size() > 0) np = (q[q.size()-1] + 1) % NF;
    end
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; fu_req = '0; flush = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NF; i++) tags[i] = P'(10 + i);
    @(negedge clock);
    reset = 1'b0; fu_req = 4'b1111; flush = 1'b0;
    #1;
    n_tests++;
    if (fu_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", fu_grant); end
    n_tests++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_src !== '0) begin
      n_fail++; $display("FAIL reset_cdb got v=%b t=%h s=%h exp zeros", cdb_valid, cdb_tag, cdb_src);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if (fu_grant !== 4'b0011) begin n_fail++; $display("FAIL reset_first_grant got=%b exp=0011", fu_grant); end
    @(posedge clock); #1;
    n_tests++;
    if (cdb_valid !== 2'b11 || cdb_tag !== {6'd11, 6'd10} || cdb_src !== {2'd1, 2'd0}) begin
      n_fail++; $display("FAIL reset_first_cdb got v=%b t=%h s=%h exp v=11 t=%h s=4", cdb_valid, cdb_tag, cdb_src, {6'd11, 6'd10});
    end
    @(negedge clock);
    #1; // pointer now 2 -> FUs 2,3 first
    n_tests++;
    if (fu_grant !== 4'b1100) begin n_fail++; $display("FAIL reset_ptr2 got=%b exp=1100", fu_grant); end
  endtask

  task automatic test_round_robin();
    logic [NF-1:0]  exp_g [3];
    logic [W*P-1:0] exp_t [3];
    exp_g[0] = 4'b0011; exp_g[1] = 4'b1100; exp_g[2] = 4'b0011;
    exp_t[0] = {6'd11, 6'd10}; exp_t[1] = {6'd13, 6'd12}; exp_t[2] = {6'd11, 6'd10};
    apply_reset();
    fu_req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (fu_grant !== exp_g[c]) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, fu_grant, exp_g[c]); end
      @(posedge clock); #1;
      n_tests++;
      if (cdb_valid !== 2'b11 || cdb_tag !== exp_t[c]) begin
        n_fail++; $display("FAIL rr_cdb[%0d] got v=%b t=%h exp v=11 t=%h", c, cdb_valid, cdb_tag, exp_t[c]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_single_and_wrap();
    apply_reset();
    tags[2] = 6'd20;
    fu_req = 4'b0100;
    #1;
    n_tests++;
    if (fu_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", fu_grant); end
    @(posedge clock); #1;
    n_tests++;
    if (cdb_valid !== 2'b01 || cdb_tag !== {6'd0, 6'd20} || cdb_src !== {2'd0, 2'd2}) begin
      n_fail++; $display("FAIL single_cdb got v=%b t=%h s=%h exp v=01 t=014 s=2", cdb_valid, cdb_tag, cdb_src);
    end
    @(negedge clock);
    fu_req = 4'b1001;   // pointer is 3: FU3 wins slot 0, wraps to FU0 for slot 1
    #1;
    n_tests++;
    if (fu_grant !== 4'b1001) begin n_fail++; $display("FAIL wrap_grant got=%b exp=1001", fu_grant); end
    @(posedge clock); #1;
    n_tests++;
    if (cdb_valid !== 2'b11 || cdb_tag !== {6'd10, 6'd13} || cdb_src !== {2'd0, 2'd3}) begin
      n_fail++; $display("FAIL wrap_cdb got v=%b t=%h s=%h exp v=11 t=%h s=3", cdb_valid, cdb_tag, cdb_src, {6'd10, 6'd13});
    end
    @(negedge clock);
    fu_req = 4'b1111;   // pointer now 1
    #1;
    n_tests++;
    if (fu_grant !== 4'b0110) begin n_fail++; $display("FAIL wrap_ptr1 got=%b exp=0110", fu_grant); end
    tags[2] = 6'd12;
  endtask

  task automatic test_flush();
    apply_reset();
    fu_req = 4'b1111;
    @(posedge clock); #1;          // pointer -> 2
    @(negedge clock);
    flush = 1'b1;
    #1;
    n_tests++;
    if (fu_grant !== 4'b0000) begin n_fail++; $display("FAIL flush_grant got=%b exp=0000", fu_grant); end
    @(posedge clock); #1;
    n_tests++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_src !== '0) begin
      n_fail++; $display("FAIL flush_cdb got v=%b t=%h s=%h exp zeros", cdb_valid, cdb_tag, cdb_src);
    end
    @(negedge clock);
    flush = 1'b0;
    #1;
    n_tests++;
    if (fu_grant !== 4'b1100) begin n_fail++; $display("FAIL flush_resume got=%b exp=1100", fu_grant); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    fu_req = 4'b1111;
    @(posedge clock); #1;
    n_tests++;
    if (cdb_valid !== 2'b11) begin n_fail++; $display("FAIL async_pre got=%b exp=11", cdb_valid); end
    #2;
    reset = 1'b0;          // mid-cycle, no clock edge
    #1;
    n_tests++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0 || fu_grant !== 4'b0000) begin
      n_fail++; $display("FAIL async_drop got v=%b t=%h g=%b exp zeros", cdb_valid, cdb_tag, fu_grant);
    end
    @(negedge clock);
    reset = 1'b1;
    m_ptr = 0;
    fu_req = '0;
  endtask

  task automatic test_rob();
    int rob_log[$];
    int rob_phy[$];
    logic rob_done[$];
    int ret_log[$];
    int ret_phy[$];
    apply_reset();
    rob_log.push_back(1); rob_phy.push_back(10); rob_done.push_back(1'b0);
    rob_log.push_back(2); rob_phy.push_back(11); rob_done.push_back(1'b0);
    tags[0] = 6'd10; tags[1] = 6'd11;
    fu_req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      if (fu_grant == 4'b0000) fu_req = '0;
      for (int k = 0; k < W; k++)
        if (cdb_valid[k])
          foreach (rob_phy[e]) if (rob_phy[e] == int'(cdb_tag[k*P +: P])) rob_done[e] = 1'b1;
      while (rob_done.size() > 0 && rob_done[0]) begin
        ret_log.push_back(rob_log.pop_front()); ret_phy.push_back(rob_phy.pop_front());
        void'(rob_done.pop_front());
      end
      @(negedge clock);
      fu_req = '0;
    end
    n_tests++;
    if (ret_log.size() != 2 || ret_log[0] != 1 || ret_phy[0] != 10 || ret_log[1] != 2 || ret_phy[1] != 11) begin
      n_fail++; $display("FAIL rob_retire got n=%0d exp 2 entries (1,10),(2,11)", ret_log.size());
    end
  endtask

  task automatic test_random();
    logic [NF-1:0]  eg;
    logic [W-1:0]   ev;
    logic [W*P-1:0] et;
    logic [W*2-1:0] es;
    int np;
    int wait_cnt [NF];
    int errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < NF; i++) wait_cnt[i] = 0;
    fu_req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++)
        if (!fu_req[i] && ($urandom_range(0, 2) != 0)) begin
          fu_req[i] = 1'b1; tags[i] = P'($urandom);
        end
      flush = ($urandom_range(0, 7) == 0);
      #1;
      model(fu_req, flush, m_ptr, eg, ev, et, es, np);
      n_tests++;
      if (fu_grant !== eg) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_grant[%0d] got=%b exp=%b", c, fu_grant, eg); end
      @(posedge clock); #1;
      n_tests++;
      if (cdb_valid !== ev || cdb_tag !== et || cdb_src !== es) begin n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_cdb[%0d] got v=%b t=%h s=%h exp v=%b t=%h s=%h", c, cdb_valid, cdb_tag, cdb_src, ev, et, es);
      end
      m_ptr = np;
      for (int i = 0; i < NF; i++) begin
        if (eg[i]) begin
          wait_cnt[i] = 0;
          fu_req[i] = ($urandom_range(0, 1) == 1);
          if (fu_req[i]) tags[i] = P'($urandom);
        end else if (fu_req[i] && !flush) begin
          wait_cnt[i]++;
          if (wait_cnt[i] >= (NF + W - 1) / W) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_starve fu=%0d waited=%0d limit=%0d", i, wait_cnt[i], (NF + W - 1) / W);
            wait_cnt[i] = 0;
          end
        end
      end
      @(negedge clock);
    end
    flush = 1'b0;
    fu_req = '0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_ptr = 0;
    reset = 1'b0; flush = 1'b0; fu_req = '0;
    for (int i = 0; i < NF; i++) tags[i] = P'(10 + i);
    test_reset();
    test_round_robin();
    test_single_and_wrap();
    test_flush();
    test_async_reset();
    test_rob();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
